// File: rtl/aes_key_expand.sv
// AES-128 key schedule: expands key_i into round keys 0..10, one round key per
// clock, held in a register bank that stays valid until the next accepted start.
module aes_key_expand (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [127:0]       key_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               key_valid_o,
  output logic [10:0][127:0] round_key_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  state_t       state;
  state_t       state_next;
  logic [3:0]   r;
  logic         start_ok;
  logic [7:0]   rcon;
  logic [127:0] prev_key;
  logic [127:0] next_key;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  t_word;
  logic [31:0]  n0, n1, n2, n3;

  // A start while an expansion is running is dropped entirely.
  assign start_ok    = start_i && (state != EXPAND);
  assign busy_o      = (state == EXPAND);
  assign key_valid_o = (state == DONE);

  always_comb begin
    // NOTE: default assigned first so no path through the case leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      IDLE, DONE: if (start_i) state_next = EXPAND;
      EXPAND:     if (r == 4'd10) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    rcon = 8'h00;
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  // Previous round key selected from the bank; the single SubWord below is shared by all rounds.
  always_comb begin
    prev_key = '0;
    for (int i = 0; i < 10; i++) begin
      if (r == 4'(i + 1)) prev_key = round_key_o[i];
    end
  end

  assign {w0, w1, w2, w3} = prev_key;
  assign t_word   = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h0};
  assign n0       = w0 ^ t_word;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments in every clocked block so all flops update from pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the round key bank is reset too; it drives the cipher core directly and must read zero after reset.
    if (!rst_n) begin
      r           <= 4'd0;
      done_o      <= 1'b0;
      round_key_o <= '0;
    end else begin
      done_o <= (state == EXPAND) && (r == 4'd10);
      if (start_ok) begin
        round_key_o[0] <= key_i;
        r              <= 4'd1;
      end else if (state == EXPAND) begin
        for (int i = 1; i <= 10; i++) begin
          if (r == 4'(i)) round_key_o[i] <= next_key;
        end
        r <= (r == 4'd10) ? 4'd0 : r + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand: randomized keys against a FIPS-197
// style word-schedule model, plus a behavioural AES-128 core fed by the round keys.
module tb_aes_key_expand;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               start_i = 1'b0;
  logic [127:0]       key_i = '0;
  logic               busy_o;
  logic               done_o;
  logic               key_valid_o;
  logic [10:0][127:0] round_key_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] sb [256];

  aes_key_expand dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .key_i       (key_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .key_valid_o (key_valid_o),
    .round_key_o (round_key_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    logic [15:0] d;
    d = {b, b} << k;
    return d[15:8];
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (x != 0 && gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [10:0][127:0] model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [10:0][127:0] out;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 11; k++) out[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    return out;
  endfunction

  function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [10:0][127:0] rk);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] ct;
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ rk[0][127 - 8*i -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int row = 0; row < 4; row++)
        for (int c = 0; c < 4; c++) s[row + 4*c] = t[row + 4*((c + row) % 4)];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03);
          s[4*c+3] = gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[rnd][127 - 8*i -: 8];
    end
    for (int i = 0; i < 16; i++) ct[127 - 8*i -: 8] = s[i];
    return ct;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_keys(input string tag, input logic [127:0] key);
    logic [10:0][127:0] exp;
    exp = model_expand(key);
    for (int i = 0; i < 11; i++) check($sformatf("%s rk%0d", tag, i), round_key_o[i], exp[i]);
  endtask

  // Accept one expansion and follow it to done_o; pulse_mask[c] raises start_i
  // with a junk key before the edge that follows sample c (c=0 is after the accepting edge).
  task automatic run_expand(input logic [127:0] key, input logic [31:0] pulse_mask, input string tag);
    int cyc;
    int busy_cnt;
    int valid_cnt;
    key_i   = key;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check($sformatf("%s busy after accept", tag), busy_o, 1);
    check($sformatf("%s valid after accept", tag), key_valid_o, 0);
    check($sformatf("%s rk0 after accept", tag), round_key_o[0], key);
    cyc = 0;
    busy_cnt = 0;
    valid_cnt = 0;
    while (!done_o && cyc < 30) begin
      if (busy_o) busy_cnt++;
      if (key_valid_o) valid_cnt++;
      if (pulse_mask[cyc]) begin
        start_i = 1'b1;
        key_i   = rand128();
      end
      tick();
      start_i = 1'b0;
      cyc++;
    end
    check($sformatf("%s done latency", tag), cyc, 10);
    check($sformatf("%s busy cycles", tag), busy_cnt, 10);
    check($sformatf("%s valid during expand", tag), valid_cnt, 0);
    check($sformatf("%s valid at done", tag), key_valid_o, 1);
    check($sformatf("%s busy at done", tag), busy_o, 0);
    check_keys(tag, key);
    tick();
    check($sformatf("%s done one cycle", tag), done_o, 0);
    check($sformatf("%s valid holds", tag), key_valid_o, 1);
  endtask

  initial begin
    logic [127:0] kk [2];
    logic [127:0] pt;
    logic [127:0] exp_ct;
    logic [10:0][127:0] mk;
    int cyc;
    int valid_cnt;
    int done_cnt;
    int busy_cnt;

    build_sbox();

    #2 rst_n = 1'b0;
    tick();
    tick();
    check("reset busy", busy_o, 0);
    check("reset done", done_o, 0);
    check("reset valid", key_valid_o, 0);
    for (int i = 0; i < 11; i++) check($sformatf("reset rk%0d", i), round_key_o[i], '0);
    rst_n = 1'b1;
    tick();

    // Known-answer vectors.
    run_expand(128'h2b7e151628aed2a6abf7158809cf4f3c, 32'h0, "fips");
    check("fips rk1 golden", round_key_o[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("fips rk10 golden", round_key_o[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    run_expand(128'h0, 32'h0, "zero");
    check("zero rk1 golden", round_key_o[1], 128'h62636363626363636263636362636363);
    check("zero rk10 golden", round_key_o[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    for (int k = 0; k < 3; k++) run_expand(rand128(), 32'h0, $sformatf("rand%0d", k));

    // Starts at expansion cycles 3 and 7 must be ignored.
    run_expand(rand128(), 32'h0000_0044, "ignore");

    // Reset in the middle of an expansion.
    key_i   = rand128();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("midreset busy", busy_o, 0);
    check("midreset done", done_o, 0);
    check("midreset valid", key_valid_o, 0);
    for (int i = 0; i < 11; i++) check($sformatf("midreset rk%0d", i), round_key_o[i], '0);
    done_cnt = 0;
    busy_cnt = 0;
    repeat (3) begin
      tick();
      if (done_o) done_cnt++;
    end
    rst_n = 1'b1;
    repeat (12) begin
      tick();
      if (done_o) done_cnt++;
      if (busy_o) busy_cnt++;
    end
    check("midreset no done", done_cnt, 0);
    check("midreset stays idle", busy_cnt, 0);
    run_expand(rand128(), 32'h0, "after_reset");

    // Start accepted on the very first edge after reset release.
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    run_expand(rand128(), 32'h0, "first_edge");

    // Back-to-back with start_i held high and alternating keys.
    kk[0] = rand128();
    kk[1] = rand128();
    key_i   = kk[0];
    start_i = 1'b1;
    tick();
    for (int e = 0; e < 4; e++) begin
      key_i = kk[(e + 1) % 2];
      cyc = 0;
      valid_cnt = 0;
      while (!done_o && cyc < 30) begin
        if (key_valid_o) valid_cnt++;
        tick();
        cyc++;
      end
      check($sformatf("b2b%0d latency", e), cyc, 10);
      check($sformatf("b2b%0d valid low", e), valid_cnt, 0);
      check_keys($sformatf("b2b%0d", e), kk[e % 2]);
      if (e == 3) start_i = 1'b0;
      tick();
      check($sformatf("b2b%0d done pulse", e), done_o, 0);
      check($sformatf("b2b%0d busy", e), busy_o, (e < 3) ? 1 : 0);
      check($sformatf("b2b%0d valid", e), key_valid_o, (e < 3) ? 0 : 1);
      if (e < 3) begin
        mk = model_expand(kk[e % 2]);
        check($sformatf("b2b%0d new rk0", e), round_key_o[0], kk[(e + 1) % 2]);
        check($sformatf("b2b%0d stale rk10", e), round_key_o[10], mk[10]);
      end
    end
    repeat (5) tick();
    mk = model_expand(kk[1]);
    check("hold valid", key_valid_o, 1);
    check("hold rk10", round_key_o[10], mk[10]);

    // Round keys drive a behavioural cipher core once key_valid_o is up.
    run_expand(128'h2b7e151628aed2a6abf7158809cf4f3c, 32'h0, "cipher");
    mk = model_expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
    for (int p = 0; p < 5; p++) begin
      pt     = (p == 0) ? 128'h3243f6a8885a308d313198a2e0370734 : rand128();
      exp_ct = (p == 0) ? 128'h3925841d02dc09fbdc118597196a0b32 : aes_encrypt(pt, mk);
      check($sformatf("cipher%0d key valid", p), key_valid_o, 1);
      check($sformatf("cipher%0d ct", p), aes_encrypt(pt, round_key_o), exp_ct);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
